// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes (common with ALU control), exec FSM states
// and the bit positions of the registered result flags.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_XOR = 4'b1101;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_OVF  = 1;
  localparam int FLAG_ILL  = 2;
  localparam int NFLAGS    = 3;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU datapath: logic ops, add/sub with signed overflow, SLT and
// illegal-code detection. Shift codes produce 0 here; the exec unit owns shifts.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int NBITS = 32,
  parameter int ALUOP = 4
) (
  input  logic [ALUOP-1:0] i_op,
  input  logic [NBITS-1:0] i_a,
  input  logic [NBITS-1:0] i_b,
  output logic [NBITS-1:0] o_result,
  output logic             o_overflow,
  output logic             o_illegal
);

  logic [NBITS-1:0] w_sum;
  logic [NBITS-1:0] w_diff;
  logic             w_slt;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;
  assign w_slt  = $signed(i_a) < $signed(i_b);

  always_comb begin
    o_result   = '0;
    o_overflow = 1'b0;
    o_illegal  = 1'b0;
    case (i_op)
      OP_AND: o_result = i_a & i_b;
      OP_OR:  o_result = i_a | i_b;
      OP_NOR: o_result = ~(i_a | i_b);
      OP_XOR: o_result = i_a ^ i_b;
      OP_ADD: begin
        o_result   = w_sum;
        o_overflow = (i_a[NBITS-1] == i_b[NBITS-1]) && (w_sum[NBITS-1] != i_a[NBITS-1]);
      end
      OP_SUB: begin
        o_result   = w_diff;
        o_overflow = (i_a[NBITS-1] != i_b[NBITS-1]) && (w_diff[NBITS-1] != i_a[NBITS-1]);
      end
      OP_SLT: o_result = {{(NBITS-1){1'b0}}, w_slt};
      OP_SLL, OP_SRL, OP_SRA: o_result = '0;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops through alu_comb_core, shifts on a
// one-bit-per-cycle serial shifter, result held in an output register.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int NBITS  = 32,
  parameter int ALUOP  = 4,
  parameter int SHBITS = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [ALUOP-1:0]  i_ALUOp,
  input  logic              i_Shamt,
  input  logic [NBITS-1:0]  i_A,
  input  logic [NBITS-1:0]  i_B,
  input  logic [SHBITS-1:0] i_shamt,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [NBITS-1:0]  o_result,
  output logic              o_zero,
  output logic              o_overflow,
  output logic              o_illegal
);

  // Handshake: an op transfers on an edge where i_valid && o_ready; a result
  // transfers on an edge where o_valid && i_ready. Both may happen together.
  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_valid;
  logic [NBITS-1:0]   r_result;
  logic [NFLAGS-1:0]  r_flags;
  logic [NBITS-1:0]   r_work;
  logic [SHBITS-1:0]  r_cnt;
  logic [ALUOP-1:0]   r_shop;

  logic               w_ready;
  logic               w_accept;
  logic               w_is_shift;
  logic [SHBITS-1:0]  w_n;
  logic               w_start_shift;
  logic               w_last;
  logic [NBITS-1:0]   w_shifted;
  logic [NBITS-1:0]   w_core_res;
  logic               w_core_ovf;
  logic               w_core_ill;
  logic [NBITS-1:0]   w_load_res;
  logic [NFLAGS-1:0]  w_load_flags;
  logic [NFLAGS-1:0]  w_shift_flags;

  alu_comb_core #(
    .NBITS(NBITS),
    .ALUOP(ALUOP)
  ) u_core (
    .i_op       (i_ALUOp),
    .i_a        (i_A),
    .i_b        (i_B),
    .o_result   (w_core_res),
    .o_overflow (w_core_ovf),
    .o_illegal  (w_core_ill)
  );

  always_comb begin
    w_ready       = i_reset && (r_state == ST_IDLE) && (!r_valid || i_ready);
    w_accept      = i_valid && w_ready && !i_flush;
    w_is_shift    = is_shift_op(i_ALUOp);
    w_n           = i_Shamt ? i_shamt : i_A[SHBITS-1:0];
    w_start_shift = w_accept && w_is_shift && (w_n != '0);
    w_last        = (r_state == ST_SHIFT) && (r_cnt == SHBITS'(1));

    // A shift by zero completes immediately with B unchanged.
    w_load_res                = w_is_shift ? i_B : w_core_res;
    w_load_flags              = '0;
    w_load_flags[FLAG_ZERO]   = (w_load_res == '0);
    w_load_flags[FLAG_OVF]    = w_core_ovf;
    w_load_flags[FLAG_ILL]    = w_core_ill;

    case (r_shop)
      OP_SLL:  w_shifted = {r_work[NBITS-2:0], 1'b0};
      OP_SRA:  w_shifted = {r_work[NBITS-1], r_work[NBITS-1:1]};
      default: w_shifted = {1'b0, r_work[NBITS-1:1]};
    endcase
    w_shift_flags            = '0;
    w_shift_flags[FLAG_ZERO] = (w_shifted == '0);
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!i_reset || i_flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_start_shift) w_state_nxt = ST_SHIFT;
        ST_SHIFT: if (w_last) w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
      r_work   <= '0;
      r_cnt    <= '0;
      r_shop   <= OP_SLL;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == ST_SHIFT) begin
      r_work <= w_shifted;
      r_cnt  <= r_cnt - SHBITS'(1);
      if (w_last) begin
        r_result <= w_shifted;
        r_flags  <= w_shift_flags;
        r_valid  <= 1'b1;
      end
    end else begin
      if (r_valid && i_ready) r_valid <= 1'b0;
      if (w_start_shift) begin
        r_work  <= i_B;
        r_cnt   <= w_n;
        r_shop  <= i_ALUOp;
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_result <= w_load_res;
        r_flags  <= w_load_flags;
        r_valid  <= 1'b1;
      end
    end
  end

  assign o_ready    = w_ready;
  assign o_valid    = r_valid;
  assign o_result   = r_result;
  assign o_zero     = r_flags[FLAG_ZERO];
  assign o_overflow = r_flags[FLAG_OVF];
  assign o_illegal  = r_flags[FLAG_ILL];

endmodule
